// File: rtl/nes_input_events_pkg.sv
// Shared types for the NES input event block: button indices, event kinds
// and the packed event record carried through the queue.
package nes_pkg;

    localparam int NUM_BUTTONS = 8;

    localparam logic [2:0] BTN_A      = 3'd0;
    localparam logic [2:0] BTN_B      = 3'd1;
    localparam logic [2:0] BTN_SELECT = 3'd2;
    localparam logic [2:0] BTN_START  = 3'd3;
    localparam logic [2:0] BTN_UP     = 3'd4;
    localparam logic [2:0] BTN_DOWN   = 3'd5;
    localparam logic [2:0] BTN_LEFT   = 3'd6;
    localparam logic [2:0] BTN_RIGHT  = 3'd7;

    // Buttons at or above this index are d-pad directions and auto-repeat.
    localparam int FIRST_DIR_BTN = 4;

    typedef enum logic [1:0] {
        KIND_PRESS   = 2'b00,
        KIND_RELEASE = 2'b01,
        KIND_REPEAT  = 2'b10
    } evt_kind_t;

    typedef struct packed {
        logic [2:0] button;
        evt_kind_t  kind;
    } nes_evt_t;

endpackage

// File: rtl/nes_input_events_if.sv
// Valid/ready event stream from the input block to its consumer.
interface nes_evt_if;
    import nes_pkg::*;

    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_button;
    evt_kind_t  evt_kind;

    modport master (output evt_valid, output evt_button, output evt_kind, input evt_ready);
    modport slave  (input evt_valid, input evt_button, input evt_kind, output evt_ready);

endinterface

// File: rtl/nes_input_events_fifo.sv
// First-word-fall-through event queue; DEPTH must be a power of two, at least 2.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module nes_event_fifo
    import nes_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  nes_evt_t push_data,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output nes_evt_t head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    nes_evt_t    mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot, so a full queue can still accept.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head = empty ? nes_evt_t'('0) : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/nes_input_events.sv
// NES controller front end: synchronise and debounce eight buttons, derive
// press/release/auto-repeat events, arbitrate them into an event queue.
module nes_input_events
    import nes_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_PERIOD   = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk_900KHz,
    input  logic       reset,
    input  logic [7:0] btn_in,
    nes_evt_if.master  evt,
    output logic       overflow
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);

    localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE      = 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = 1;

    logic [7:0]        sync1;
    logic [7:0]        sync2;
    logic [7:0]        level;
    logic [DB_W-1:0]   db_cnt   [NUM_BUTTONS];
    logic [HOLD_W-1:0] hold_cnt [NUM_BUTTONS];

    logic [7:0] flip;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] rep_fire;

    logic [7:0] press_pend;
    logic [7:0] rel_pend;
    logic [7:0] rep_pend;
    logic [7:0] clr_press;
    logic [7:0] clr_rel;
    logic [7:0] clr_rep;

    logic       sel_valid;
    logic [2:0] sel_idx;
    evt_kind_t  sel_kind;
    nes_evt_t   sel_evt;
    nes_evt_t   head;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       ovf_event;

    always_ff @(posedge clk_900KHz) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    always_comb begin
        flip     = '0;
        rise     = '0;
        fall     = '0;
        rep_fire = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            flip[i] = (sync2[i] != level[i]) && (db_cnt[i] == DB_LAST);
            rise[i] = flip[i] && sync2[i];
            fall[i] = flip[i] && !sync2[i];
            // A flip edge always wins over a repeat on the same edge.
            if (i >= FIRST_DIR_BTN)
                rep_fire[i] = level[i] && !flip[i] && (hold_cnt[i] == HOLD_LAST);
        end
    end

    always_ff @(posedge clk_900KHz) begin
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (reset) begin
                db_cnt[i] <= '0;
                level[i]  <= 1'b0;
            end else if (sync2[i] == level[i]) begin
                db_cnt[i] <= '0;
            end else if (flip[i]) begin
                db_cnt[i] <= '0;
                level[i]  <= sync2[i];
            end else begin
                db_cnt[i] <= db_cnt[i] + DB_ONE;
            end
        end
    end

    always_ff @(posedge clk_900KHz) begin
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (reset || (i < FIRST_DIR_BTN) || flip[i])
                hold_cnt[i] <= '0;
            else if (rep_fire[i])
                hold_cnt[i] <= HOLD_RELOAD;
            else if (level[i])
                hold_cnt[i] <= hold_cnt[i] + HOLD_ONE;
        end
    end

    // Lowest index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_kind  = KIND_PRESS;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (press_pend[i] || rel_pend[i] || rep_pend[i]) begin
                sel_valid = 1'b1;
                sel_idx   = 3'(i);
                if (press_pend[i])     sel_kind = KIND_PRESS;
                else if (rel_pend[i])  sel_kind = KIND_RELEASE;
                else                   sel_kind = KIND_REPEAT;
            end
        end
    end

    assign fifo_pop  = evt.evt_ready && !fifo_empty;
    assign fifo_push = sel_valid && (!fifo_full || fifo_pop);

    always_comb begin
        clr_press = '0;
        clr_rel   = '0;
        clr_rep   = '0;
        if (fifo_push) begin
            case (sel_kind)
                KIND_PRESS:   clr_press[sel_idx] = 1'b1;
                KIND_RELEASE: clr_rel[sel_idx]   = 1'b1;
                default:      clr_rep[sel_idx]   = 1'b1;
            endcase
        end
    end

    // A new pending bit landing on one that is still set (and not being
    // serviced this edge) merges two events into one.
    assign ovf_event = |(press_pend & ~clr_press & rise)
                     | |(rel_pend   & ~clr_rel   & fall)
                     | |(rep_pend   & ~clr_rep   & rep_fire);

    always_ff @(posedge clk_900KHz) begin
        if (reset) begin
            press_pend <= '0;
            rel_pend   <= '0;
            rep_pend   <= '0;
            overflow   <= 1'b0;
        end else begin
            press_pend <= (press_pend & ~clr_press) | rise;
            rel_pend   <= (rel_pend & ~clr_rel) | fall;
            rep_pend   <= (rep_pend & ~clr_rep & ~fall) | rep_fire;
            if (ovf_event) overflow <= 1'b1;
        end
    end

    assign sel_evt.button = sel_idx;
    assign sel_evt.kind   = sel_kind;

    nes_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_900KHz),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (sel_evt),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    assign evt.evt_valid  = !fifo_empty;
    assign evt.evt_button = head.button;
    assign evt.evt_kind   = head.kind;

endmodule

// File: doc/nes_input_events.md
NES_INPUT_EVENTS -- requirements
Module: nes_input_events

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive cycles a new level must hold before it is accepted.
REQ-002 Parameter REPEAT_DELAY, default 20, cycles from an accepted direction press to its first repeat.
REQ-003 Parameter REPEAT_PERIOD, default 8, cycles between subsequent repeats; must be ≥1 and ≤ REPEAT_DELAY.
REQ-004 Parameter FIFO_DEPTH, default 4, event queue entries; must be a power of two.
REQ-005 clk_900KHz  in  1  sole clock; all flops update on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 btn_in  in  8  active-high button levels: bit0 a, 1 b, 2 select, 3 start, 4 up, 5 down, 6 left, 7 right.
REQ-008 evt_valid  out  1  queue head holds an event.
REQ-009 evt_ready  in  1  consumer accepts head; pop occurs on an edge with evt_valid and evt_ready both high.
REQ-010 evt_button  out  3  button index of head event.
REQ-011 evt_kind  out  2  00 press, 01 release, 10 repeat; 11 never produced.
REQ-012 overflow  out  1  sticky flag: an event was coalesced or lost.

Function
REQ-013 btn_in passes through a 2-flop synchronizer per bit; only the second stage feeds the debounce logic.
REQ-014 Per button: a counter increments on each edge where the synchronized level differs from the accepted level and clears on each edge where they match.
REQ-015 The accepted level flips on the edge where the counter would reach DEBOUNCE_CYCLES; the counter clears on that edge.
REQ-016 Input change first sampled at edge 1 flips the accepted level at edge 2+DEBOUNCE_CYCLES; pulses shorter than DEBOUNCE_CYCLES produce no event.
REQ-017 Accepted 0→1 sets the press-pending bit and accepted 1→0 sets the release-pending bit for that button, both on the flip edge.
REQ-018 Buttons 4–7 only: a hold counter clears on press; each cycle while accepted is high it increments; on reaching REPEAT_DELAY it sets repeat-pending and reloads REPEAT_DELAY−REPEAT_PERIOD.
REQ-019 Repeats therefore occur REPEAT_DELAY, +REPEAT_PERIOD, +2·REPEAT_PERIOD… cycles after the press flip edge.
REQ-020 Buttons 0–3 never generate repeat events.
REQ-021 On a release flip, that button's repeat-pending bit and hold counter clear.
REQ-022 Arbiter: each cycle, select the lowest-indexed button with any pending bit; within a button, priority is press > release > repeat.
REQ-023 Selection writes one entry into the FIFO on the next edge if the FIFO is not full or is popped on that same edge; the serviced pending bit clears on that edge.
REQ-024 When the FIFO is full with no pop, pending bits hold (backpressure) and no event is lost.
REQ-025 A repeat arriving while that button's repeat-pending is already set is coalesced and sets overflow.
REQ-026 A release arriving while press-pending is still set keeps both; press is emitted first.
REQ-027 FIFO is first-word-fall-through: evt_valid = not empty; evt_button/evt_kind show head; outputs are 0 when empty.
REQ-028 End-to-end latency, uncontended: evt_valid rises after edge 3+DEBOUNCE_CYCLES from first sampling of the input change.
REQ-029 overflow stays high until reset.

Reset
REQ-030 On any edge with reset high: synchronizers, accepted levels, counters, pending bits, FIFO pointers and overflow go to 0; evt_valid, evt_button, evt_kind read 0 on the following cycle.
REQ-031 Reset asserted mid-operation discards queued and pending events; a button held through reset produces a press after normal debounce once reset deasserts.

Structure
REQ-032 Package nes_pkg holds button index constants, the evt_kind enumeration and the packed event typedef {button[2:0], kind[1:0]}.
REQ-033 Sub-module nes_event_fifo implements the FWFT queue (push/pop/full/empty, wrap-around pointers with extra MSB).

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, FIFO_DEPTH=4, evt_ready=1 unless stated)
REQ-034 Raise btn_in[0], hold 30 cycles -> single event {0, press}, evt_valid high after edge 7, one cycle only; no repeat.
REQ-035 3-cycle pulse on btn_in[1] -> no event; 4-cycle pulse -> press then release.
REQ-036 Hold btn_in[4] 45 cycles after its press flip -> press, repeats at +20, +28, +36, +44, then release after drop.
REQ-037 Raise btn_in[7] and btn_in[2] on the same cycle -> {2,press} precedes {7,press} on consecutive cycles.
REQ-038 evt_ready=0, six buttons pressed -> 4 queued events, 2 held pending, overflow=0; after ready=1 all six drain in index order.
REQ-039 Assert reset with 3 events queued -> evt_valid=0 and overflow=0 the next cycle; buttons still held re-report press after 7 edges.
